// File: rtl/conv_encoder_tx.sv
// Rate-1/2 convolutional encoder (K=3, G0=111, G1=101) with a valid/ready symbol output.
// Optional zero-tail termination is enabled by defining ENC_TAIL_EN.
module conv_encoder_tx #(
  parameter int unsigned N  = 8,
  parameter int unsigned K  = 3,
  parameter logic [K-1:0] G0 = 3'b111,
  parameter logic [K-1:0] G1 = 3'b101
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] data_in,
  output logic [1:0]   sym_out,
  output logic         sym_valid,
  input  logic         sym_ready,
  output logic         busy,
  output logic         done
);

  localparam int unsigned SR_W  = K - 1;
  localparam int unsigned CNT_W = $clog2(N + K);
`ifdef ENC_TAIL_EN
  localparam int unsigned LAST_IDX = N + K - 2;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ENC = 2'd1, S_TAIL = 2'd2, S_DONE = 2'd3} state_t;
`else
  localparam int unsigned LAST_IDX = N - 1;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ENC = 2'd1, S_DONE = 2'd3} state_t;
`endif

  state_t             r_state, w_state_nxt;
  logic [SR_W-1:0]    r_sr, w_sr_nxt;
  logic [N-1:0]       r_frame, w_frame_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]         r_sym, w_sym_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_busy;
  logic               r_done, w_done_nxt;
  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  logic               w_xfer;
  logic [K-1:0]       w_u;

  // Reset asserts asynchronously, releases two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_xfer = r_valid & sym_ready;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_frame <= '0;
      r_cnt   <= '0;
      r_sym   <= 2'b00;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_frame <= w_frame_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sym   <= w_sym_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_valid_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Frame register shifts left with zero fill, so its MSB is also the tail bit.
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_frame_nxt = r_frame;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_frame_nxt = data_in;
          w_sr_nxt    = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_ENC;
        end
      end
      S_ENC: begin
        if (w_xfer) begin
          w_sr_nxt    = {r_frame[N-1], r_sr[SR_W-1:1]};
          w_frame_nxt = {r_frame[N-2:0], 1'b0};
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(N - 1)) begin
`ifdef ENC_TAIL_EN
            w_state_nxt = S_TAIL;
`else
            w_state_nxt = S_DONE;
`endif
          end
        end
      end
`ifdef ENC_TAIL_EN
      S_TAIL: begin
        if (w_xfer) begin
          w_sr_nxt  = {1'b0, r_sr[SR_W-1:1]};
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(LAST_IDX)) w_state_nxt = S_DONE;
        end
      end
`endif
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next symbol is computed from next-state values so outputs stay registered with no bubble.
  always_comb begin
    w_valid_nxt = (w_state_nxt == S_ENC);
`ifdef ENC_TAIL_EN
    w_valid_nxt = w_valid_nxt | (w_state_nxt == S_TAIL);
`endif
    w_done_nxt = (w_state_nxt == S_DONE);
    w_u        = {w_frame_nxt[N-1], w_sr_nxt};
    w_sym_nxt  = 2'b00;
    if (w_valid_nxt) w_sym_nxt = {^(w_u & G0), ^(w_u & G1)};
  end

  assign sym_out   = r_sym;
  assign sym_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
